// File: rtl/fp_align_pkg.sv
// Shared definitions for the FP adder exponent-compare / mantissa-align path.
package fp_align_pkg;

   // Guard, round and sticky bits appended below the aligned mantissa.
   localparam int GRS_W = 3;

   // A difference beyond MAN_W+2 shifts even the hidden bit past the sticky
   // position, so the small operand can only contribute a sticky bit.
   function automatic logic too_big_f(input logic [31:0] diff, input int man_w);
      return diff > 32'(man_w + 2);
   endfunction

endpackage

// File: rtl/fp_sticky_shr.sv
// Combinational right shifter that appends G/R/S bits and folds every bit
// shifted out below the sticky position back into the sticky bit.
module fp_sticky_shr
   import fp_align_pkg::*;
#(
   parameter int W  = 24,
   parameter int SW = 9
) (
   input  logic [W-1:0]       man,
   input  logic [SW-1:0]      sh,
   output logic [W+GRS_W-1:0] al
);

   localparam int EW = W + GRS_W;

   logic [EW-1:0] ext;
   logic [EW-1:0] shifted;
   logic [EW-1:0] lost_mask;

   // Shift the extended mantissa and OR the lost bits into bit 0.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path; a missed
      // assignment would infer a latch.
      ext       = {man, {GRS_W{1'b0}}};
      shifted   = ext >> sh;
      lost_mask = ~({EW{1'b1}} << sh);
      al        = {shifted[EW-1:1], shifted[0] | (|(ext & lost_mask))};
   end

endmodule

// File: rtl/fp_exp_align_pipe.sv
// Two-stage exponent compare and mantissa align unit with valid/ready flow
// control. Stage 1 orders the operands, stage 2 aligns the smaller mantissa.
module fp_exp_align_pipe
   import fp_align_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 24,
   parameter int SHW   = $clog2(MAN_W + 3)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W-1:0]       exp_a,
   input  logic [EXP_W-1:0]       exp_b,
   input  logic [MAN_W-1:0]       man_a,
   input  logic [MAN_W-1:0]       man_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W-1:0]       exp_big,
   output logic [MAN_W-1:0]       man_big,
   output logic [MAN_W+GRS_W-1:0] man_small_al,
   output logic [SHW-1:0]         nshift,
   output logic                   swapped,
   output logic                   too_big
);

   // Stage-1 payload; widths follow the instance parameters.
   typedef struct packed {
      logic [EXP_W-1:0] exp_big;
      logic [MAN_W-1:0] man_big;
      logic [MAN_W-1:0] man_small;
      logic [EXP_W:0]   diff;
      logic             swapped;
      logic             too_big;
   } align_s1_t;

   align_s1_t s1_d;
   align_s1_t s1_q;
   logic      v1;
   logic      en1;
   logic      en2;
   logic [EXP_W:0] diff_ab;
   logic [EXP_W:0] diff_ba;
   logic           b_exp_gt;
   logic [MAN_W+GRS_W-1:0] shr_al;
   logic [MAN_W+GRS_W-1:0] al_d;
   logic [SHW-1:0]         nshift_d;

   // A stage advances when the stage after it can take its contents.
   assign en2      = out_ready || !out_valid;
   assign en1      = en2 || !v1;
   assign in_ready = en1;

   // Compare exponents with one extra bit so the largest difference never wraps.
   always_comb begin
      diff_ab  = {1'b0, exp_a} - {1'b0, exp_b};
      diff_ba  = {1'b0, exp_b} - {1'b0, exp_a};
      b_exp_gt = diff_ab[EXP_W];
      s1_d.swapped   = b_exp_gt || ((exp_a == exp_b) && (man_b > man_a));
      s1_d.exp_big   = s1_d.swapped ? exp_b : exp_a;
      s1_d.man_big   = s1_d.swapped ? man_b : man_a;
      s1_d.man_small = s1_d.swapped ? man_a : man_b;
      s1_d.diff      = b_exp_gt ? diff_ba : diff_ab;
      s1_d.too_big   = too_big_f(32'(s1_d.diff), MAN_W);
   end

   // Stage 1 register: flush wins over a same-cycle input transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         v1   <= 1'b0;
         s1_q <= '0;
      end else begin
         if (flush)    v1 <= 1'b0;
         else if (en1) v1 <= in_valid;
         if (en1 && in_valid) s1_q <= s1_d;
      end
   end

   fp_sticky_shr #(
      .W  (MAN_W),
      .SW (EXP_W + 1)
   ) u_shr (
      .man (s1_q.man_small),
      .sh  (s1_q.diff),
      .al  (shr_al)
   );

   // Out-of-range differences collapse the small operand to a lone sticky bit.
   always_comb begin
      al_d     = shr_al;
      nshift_d = s1_q.diff[SHW-1:0];
      if (s1_q.too_big) begin
         al_d     = {{(MAN_W + GRS_W - 1){1'b0}}, |s1_q.man_small};
         nshift_d = '0;
      end
   end

   // Stage 2 register: outputs hold while the downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the output registers are reset too, so every output reads 0 as
      // soon as rst_n falls instead of exposing stale in-flight data.
      if (!rst_n) begin
         out_valid    <= 1'b0;
         exp_big      <= '0;
         man_big      <= '0;
         man_small_al <= '0;
         nshift       <= '0;
         swapped      <= 1'b0;
         too_big      <= 1'b0;
      end else begin
         if (flush)    out_valid <= 1'b0;
         else if (en2) out_valid <= v1;
         if (en2 && v1) begin
            exp_big      <= s1_q.exp_big;
            man_big      <= s1_q.man_big;
            man_small_al <= al_d;
            nshift       <= nshift_d;
            swapped      <= s1_q.swapped;
            too_big      <= s1_q.too_big;
         end
      end
   end

endmodule

// File: tb/tb_fp_exp_align_pipe.sv
// Directed bench for fp_exp_align_pipe (EXP_W=8, MAN_W=24): a vector table
// with hand-computed results plus stall, flush and reset sequences.
module tb_fp_exp_align_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  exp_a, exp_b;
   logic [23:0] man_a, man_b;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  exp_big;
   logic [23:0] man_big;
   logic [26:0] man_small_al;
   logic [4:0]  nshift;
   logic        swapped;
   logic        too_big;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  ea, eb;
      logic [23:0] ma, mb;
      logic [7:0]  x_exp;
      logic [23:0] x_man;
      logic [26:0] x_al;
      logic [4:0]  x_nsh;
      logic        x_sw;
      logic        x_tb;
   } vec_t;

   vec_t vecs[10];
   vec_t str[4];

   fp_exp_align_pipe #(.EXP_W(8), .MAN_W(24)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .exp_a        (exp_a),
      .exp_b        (exp_b),
      .man_a        (man_a),
      .man_b        (man_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .exp_big      (exp_big),
      .man_big      (man_big),
      .man_small_al (man_small_al),
      .nshift       (nshift),
      .swapped      (swapped),
      .too_big      (too_big)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input vec_t v, input string tag);
      check({tag, "_exp_big"},  64'(exp_big),      64'(v.x_exp));
      check({tag, "_man_big"},  64'(man_big),      64'(v.x_man));
      check({tag, "_al"},       64'(man_small_al), 64'(v.x_al));
      check({tag, "_nshift"},   64'(nshift),       64'(v.x_nsh));
      check({tag, "_swapped"},  64'(swapped),      64'(v.x_sw));
      check({tag, "_too_big"},  64'(too_big),      64'(v.x_tb));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid),    64'd0);
      check({tag, "_exp_big"},   64'(exp_big),      64'd0);
      check({tag, "_man_big"},   64'(man_big),      64'd0);
      check({tag, "_al"},        64'(man_small_al), 64'd0);
      check({tag, "_nshift"},    64'(nshift),       64'd0);
      check({tag, "_swapped"},   64'(swapped),      64'd0);
      check({tag, "_too_big"},   64'(too_big),      64'd0);
   endtask

   task automatic drive(input vec_t v);
      exp_a = v.ea;
      exp_b = v.eb;
      man_a = v.ma;
      man_b = v.mb;
   endtask

   // One isolated transfer into an empty pipe: result must appear exactly two
   // edges after acceptance.
   task automatic run_vec(input vec_t v, input string tag);
      @(negedge clk);
      drive(v);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_lat2_valid"}, 64'(out_valid), 64'd1);
      check_outputs(v, tag);
   endtask

   function automatic vec_t mk(input logic [7:0] ea, input logic [7:0] eb,
                               input logic [23:0] ma, input logic [23:0] mb,
                               input logic [7:0] x_exp, input logic [23:0] x_man,
                               input logic [26:0] x_al, input logic [4:0] x_nsh,
                               input logic x_sw, input logic x_tb);
      vec_t v;
      v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb;
      v.x_exp = x_exp; v.x_man = x_man; v.x_al = x_al;
      v.x_nsh = x_nsh; v.x_sw = x_sw; v.x_tb = x_tb;
      return v;
   endfunction

   initial begin
      int  nin;
      int  nout;
      int  stall_left;
      int  acc_at_stall;
      bit  stalled;
      bit  saw_low;

      //          ea     eb     ma          mb          exp    man_big     al            nsh  sw    tb
      vecs[0] = mk(8'h85, 8'h82, 24'h800000, 24'hC00001, 8'h85, 24'h800000, 27'h0C00001, 5'd3,  1'b0, 1'b0);
      vecs[1] = mk(8'h80, 8'h80, 24'h800000, 24'h900000, 8'h80, 24'h900000, 27'h4000000, 5'd0,  1'b1, 1'b0);
      vecs[2] = mk(8'h90, 8'h70, 24'h800000, 24'h800000, 8'h90, 24'h800000, 27'h0000001, 5'd0,  1'b0, 1'b1);
      vecs[3] = mk(8'h8A, 8'h70, 24'h800000, 24'h800000, 8'h8A, 24'h800000, 27'h0000001, 5'd26, 1'b0, 1'b0);
      vecs[4] = mk(8'h8B, 8'h70, 24'h800000, 24'h800000, 8'h8B, 24'h800000, 27'h0000001, 5'd0,  1'b0, 1'b1);
      vecs[5] = mk(8'h00, 8'hFF, 24'h400000, 24'h800000, 8'hFF, 24'h800000, 27'h0000001, 5'd0,  1'b1, 1'b1);
      vecs[6] = mk(8'h7F, 8'h7F, 24'hA5A5A5, 24'hA5A5A5, 8'h7F, 24'hA5A5A5, 27'h52D2D28, 5'd0,  1'b0, 1'b0);
      vecs[7] = mk(8'h84, 8'h80, 24'hC00000, 24'h800001, 8'h84, 24'hC00000, 27'h0400001, 5'd4,  1'b0, 1'b0);
      vecs[8] = mk(8'h10, 8'h10, 24'h800001, 24'h800000, 8'h10, 24'h800001, 27'h4000000, 5'd0,  1'b0, 1'b0);
      vecs[9] = mk(8'h70, 8'h89, 24'hC00000, 24'h800000, 8'h89, 24'h800000, 27'h0000003, 5'd25, 1'b1, 1'b0);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      exp_a = '0; exp_b = '0; man_a = '0; man_b = '0;

      // Reset state.
      #12;
      check_zero("reset");
      #5 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_in_ready", 64'(in_ready), 64'd1);
      check("post_reset_out_valid", 64'(out_valid), 64'd0);

      // Table-driven vectors.
      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back stream with a 3-cycle downstream stall.
      str[0] = vecs[0]; str[1] = vecs[1]; str[2] = vecs[7]; str[3] = vecs[9];
      nin = 0; nout = 0; stall_left = 0; acc_at_stall = -1; stalled = 0; saw_low = 0;
      for (int cyc = 0; cyc < 40 && nout < 4; cyc++) begin
         @(negedge clk);
         if (out_valid && !stalled) begin
            stalled      = 1;
            stall_left   = 3;
            acc_at_stall = nin;
         end
         out_ready = (stall_left == 0);
         if (nin < 4) begin
            in_valid = 1'b1;
            drive(str[nin]);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stall_left > 0) begin
            check_outputs(str[0], "stall_hold");
            if (!in_ready) saw_low = 1;
            stall_left--;
         end
         if (out_valid && out_ready) begin
            check_outputs(str[nout], $sformatf("stream%0d", nout));
            nout++;
         end
         if (in_valid && in_ready) nin++;
      end
      check("stream_results", 64'(nout), 64'd4);
      check("stream_accepts_before_stall", 64'(acc_at_stall), 64'd2);
      check("stream_in_ready_fell", 64'(saw_low), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("stream_no_duplicate", 64'(out_valid), 64'd0);

      // Flush with both stages full and a new input offered.
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      drive(vecs[2]);
      @(negedge clk);
      drive(vecs[3]);
      @(negedge clk);
      check("flush_pre_valid", 64'(out_valid), 64'd1);
      drive(vecs[4]);
      flush = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("flush_no_stale%0d", k), 64'(out_valid), 64'd0);
      end

      // Asynchronous reset mid-stream with a result held under stall.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(vecs[0]);
      @(negedge clk);
      drive(vecs[7]);
      @(negedge clk);
      in_valid = 1'b0;
      check("rst_pre_valid", 64'(out_valid), 64'd1);
      check_outputs(vecs[0], "rst_pre");
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      #3 rst_n = 1'b1;
      run_vec(vecs[5], "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
